reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Board-level reset and bring-up sequencer for multi-PLL, multi-domain designs.
//  Monitors any number of PLL lock inputs, stretches reset, then releases
//  NUM_DOMAINS reset outputs one domain at a time. Each release is gated on a
//  stagger delay and on a per-domain ready ack (e.g. SDRAM init done).
//  Detects lock loss and ready timeouts, and drives a heartbeat/fault status LED.
// PARAMETERS
//  LOCK_COUNT        2           number of PLL lock inputs (>=1)
//  NUM_DOMAINS       3           number of reset domains released in order (>=1)
//  STRETCH_CYCLES    32          consecutive all-locked cycles before first release (>=1)
//  STAGGER_CYCLES    16          minimum cycles between successive releases (>=1)
//  READY_TIMEOUT     1_000_000   max cycles to wait for domain_ready; 0 = disabled
//  HEARTBEAT_CYCLES  50_000_000  LED half-period in RUN (>=4)
//  FAULT_SHIFT       2           LED half-period while fault = HEARTBEAT_CYCLES>>FAULT_SHIFT
// PORTS
//  clock          in   1            system clock
//  reset          in   1            asynchronous, active-high reset
//  lock_in        in   LOCK_COUNT   raw PLL lock bits; asynchronous, 2-FF synchronised internally
//  domain_ready   in   NUM_DOMAINS  per-domain ready ack; synchronous to clock
//  fault_clear    in   1            one-cycle pulse that clears the sticky fault flag
//  domain_reset   out  NUM_DOMAINS  active-high reset per domain; bit 0 is released first
//  all_ready      out  1            1 only while state is RUN
//  fault          out  1            sticky: a lock loss or ready timeout has occurred
//  heartbeat_led  out  1            status LED
//  state_dbg      out  2            0=WAIT_LOCK 1=STRETCH 2=RELEASE 3=RUN
// BEHAVIOUR
//  Reset (async assert): domain_reset='1, all_ready=0, fault=0, heartbeat_led=0,
//   state=WAIT_LOCK, sync FFs=0, cnt=0, idx=0, led counter=0.
//  All outputs are registered. locked = AND of synchronised lock_in (2-cycle latency).
//  WAIT_LOCK: domain_reset='1. If locked: go to STRETCH with cnt<=0.
//  STRETCH: cnt++. At cnt==STRETCH_CYCLES-1 with locked: go to RELEASE, idx<=0,
//   cnt<=0, domain_reset[0]<=0 on that same edge.
//  RELEASE: cnt++. Advance when cnt>=STAGGER_CYCLES-1 AND domain_ready[idx]:
//   - idx<NUM_DOMAINS-1: idx++, cnt<=0, domain_reset[idx+1]<=0.
//   - idx==NUM_DOMAINS-1: go to RUN, all_ready<=1.
//   Only domain_ready[idx] is sampled; other ready bits are ignored.
//   Timeout: READY_TIMEOUT!=0 and cnt==READY_TIMEOUT-1 without advancing ->
//   fault<=1, domain_reset<='1, go to WAIT_LOCK.
//  RUN: holds. domain_ready deassertion is ignored.
//  Lock loss (locked==0 in STRETCH/RELEASE/RUN): on the next edge domain_reset<='1,
//   all_ready<=0, cnt<=0, idx<=0, go to WAIT_LOCK. fault<=1 only if the state was
//   RELEASE or RUN; a drop during STRETCH only restarts.
//  Priority within one cycle: lock loss > timeout > advance.
//  fault_clear clears fault; a fault set in the same cycle wins (fault stays 1).
//  Released domain_reset bits never reassert individually; they only reassert all together.
//  LED: active when state==RUN or fault==1, else LED=0 and its counter=0.
//   Half-period P = fault ? HEARTBEAT_CYCLES>>FAULT_SHIFT : HEARTBEAT_CYCLES.
//   Counter counts 0..P-1; at P-1 it wraps to 0 and toggles the LED.
//   A change of P restarts the counter from 0.
//  Counter widths: $clog2 of the largest compared value; no overflow is permitted.
// TESTING  (LOCK_COUNT=2 NUM_DOMAINS=3 STRETCH=8 STAGGER=4 TIMEOUT=20 HEARTBEAT=10)
//  1. Both lock_in high, domain_ready='1 -> domain_reset[0] falls on the 11th edge;
//     [1] falls 4 edges later, [2] 4 edges after that; all_ready 4 edges after [2].
//  2. lock_in[1] pulses low 1 cycle during STRETCH -> STRETCH restarts from WAIT_LOCK;
//     fault stays 0; release is delayed by the restart.
//  3. domain_ready[1] held 0 -> 20 cycles after domain_reset[1] falls: fault=1,
//     domain_reset=3'b111, state_dbg=0.
//  4. Lock drop in RUN -> next edge: domain_reset=3'b111, all_ready=0, fault=1;
//     LED toggles every 2 cycles. fault_clear with locks low -> LED=0.
//  5. In RUN with no fault -> heartbeat_led toggles every 10 cycles.
//     Async reset mid-RELEASE -> all outputs at reset values with no clock edge.
//  6. fault_clear in the same cycle as a timeout -> fault remains 1.

Source files
------------

// File: rtl/reset_sequencer.sv
// Board-level reset sequencer: waits for all PLLs to lock, stretches reset, then
// releases each domain in order once its stagger delay and ready ack are satisfied.
module reset_sequencer #(
    parameter int LOCK_COUNT       = 2,
    parameter int NUM_DOMAINS      = 3,
    parameter int STRETCH_CYCLES   = 32,
    parameter int STAGGER_CYCLES   = 16,
    parameter int READY_TIMEOUT    = 1_000_000,
    parameter int HEARTBEAT_CYCLES = 50_000_000,
    parameter int FAULT_SHIFT      = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [LOCK_COUNT-1:0]  lock_in,
    input  logic [NUM_DOMAINS-1:0] domain_ready,
    input  logic                   fault_clear,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   all_ready,
    output logic                   fault,
    output logic                   heartbeat_led,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STRETCH   = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int TO_M1   = (READY_TIMEOUT > 0) ? READY_TIMEOUT - 1 : 0;
    localparam int MAX_A   = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES - 1 : STAGGER_CYCLES - 1;
    localparam int CNT_MAX = (TO_M1 > MAX_A) ? TO_M1 : MAX_A;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int LED_W   = $clog2(HEARTBEAT_CYCLES);

    localparam logic [CNT_W-1:0] STRETCH_M1 = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_M1 = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TO_M1);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [LED_W-1:0] SLOW_M1    = LED_W'(HEARTBEAT_CYCLES - 1);
    localparam logic [LED_W-1:0] FAST_M1    = LED_W'((HEARTBEAT_CYCLES >> FAULT_SHIFT) - 1);

    logic [LOCK_COUNT-1:0]  sync1_q, sync2_q;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dr_q, dr_d;
    logic                   all_ready_q, all_ready_d;
    logic                   fault_q, fault_d, set_fault;
    logic                   led_q, led_d;
    logic [LED_W-1:0]       lcnt_q, lcnt_d, led_top;
    logic                   fast_q, fast_d;
    logic                   locked;

    assign locked  = &sync2_q;
    // Saturate so a long wait with the timeout disabled cannot wrap the counter.
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            idx_q       <= '0;
            dr_q        <= '1;
            all_ready_q <= 1'b0;
            fault_q     <= 1'b0;
            led_q       <= 1'b0;
            lcnt_q      <= '0;
            fast_q      <= 1'b0;
        end else begin
            sync1_q     <= lock_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dr_q        <= dr_d;
            all_ready_q <= all_ready_d;
            fault_q     <= fault_d;
            led_q       <= led_d;
            lcnt_q      <= lcnt_d;
            fast_q      <= fast_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        dr_d      = dr_q;
        set_fault = 1'b0;
        if (state_q != WAIT_LOCK && !locked) begin
            // A drop during STRETCH only restarts; later states record a fault.
            state_d   = WAIT_LOCK;
            cnt_d     = '0;
            idx_d     = '0;
            dr_d      = '1;
            set_fault = (state_q == RELEASE) || (state_q == RUN);
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    dr_d  = '1;
                    cnt_d = '0;
                    idx_d = '0;
                    if (locked) state_d = STRETCH;
                end
                STRETCH: begin
                    if (cnt_q == STRETCH_M1) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                        dr_d[0] = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                RELEASE: begin
                    if (READY_TIMEOUT != 0 && cnt_q == TIMEOUT_M1) begin
                        state_d   = WAIT_LOCK;
                        cnt_d     = '0;
                        idx_d     = '0;
                        dr_d      = '1;
                        set_fault = 1'b1;
                    end else if (cnt_q >= STAGGER_M1 && domain_ready[idx_q]) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = RUN;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            cnt_d = '0;
                            dr_d  = dr_q & ~((NUM_DOMAINS'(1) << idx_q) << 1);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
        all_ready_d = (state_d == RUN);
    end

    always_comb begin
        fault_d = fault_q;
        if (fault_clear) fault_d = 1'b0;
        if (set_fault)   fault_d = 1'b1;
    end

    // LED half-period follows the fault flag; switching period restarts the count.
    assign led_top = fault_q ? FAST_M1 : SLOW_M1;

    always_comb begin
        led_d  = led_q;
        lcnt_d = lcnt_q;
        fast_d = fault_q;
        if (!(state_q == RUN || fault_q)) begin
            led_d  = 1'b0;
            lcnt_d = '0;
        end else if (fast_q != fault_q) begin
            lcnt_d = '0;
        end else if (lcnt_q == led_top) begin
            lcnt_d = '0;
            led_d  = ~led_q;
        end else begin
            lcnt_d = lcnt_q + LED_W'(1);
        end
    end

    assign domain_reset  = dr_q;
    assign all_ready     = all_ready_q;
    assign fault         = fault_q;
    assign heartbeat_led = led_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: edge-numbered vector table for the main
// bring-up / heartbeat / lock-loss flow, plus hand sequences for corner cases.
module tb_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] lock_in = 2'b00;
    logic [2:0] domain_ready = 3'b000;
    logic       fault_clear = 1'b0;
    logic [2:0] domain_reset;
    logic       all_ready;
    logic       fault;
    logic       heartbeat_led;
    logic [1:0] state_dbg;

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;

    always #5 clock = ~clock;

    reset_sequencer #(
        .LOCK_COUNT(2), .NUM_DOMAINS(3), .STRETCH_CYCLES(8), .STAGGER_CYCLES(4),
        .READY_TIMEOUT(20), .HEARTBEAT_CYCLES(10), .FAULT_SHIFT(2)
    ) dut (
        .clock(clock), .reset(reset), .lock_in(lock_in), .domain_ready(domain_ready),
        .fault_clear(fault_clear), .domain_reset(domain_reset), .all_ready(all_ready),
        .fault(fault), .heartbeat_led(heartbeat_led), .state_dbg(state_dbg)
    );

    typedef struct {
        int         adv;
        logic [1:0] lock;
        logic [2:0] rdy;
        logic       clr;
        logic [2:0] dr;
        logic       ar;
        logic [1:0] st;
        logic       flt;
        logic       led;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            edge_n++;
            @(negedge clock);
        end
    endtask

    task automatic do_reset(input logic [1:0] lk, input logic [2:0] rdy);
        reset        = 1'b1;
        lock_in      = lk;
        domain_ready = rdy;
        fault_clear  = 1'b0;
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        edge_n = 0;
    endtask

    task automatic wait_dr(input logic [2:0] target, input int budget, output int n);
        n = -1;
        for (int i = 0; i < budget && n < 0; i++) begin
            tick(1);
            if (domain_reset === target) n = edge_n;
        end
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget, output int n);
        n = -1;
        for (int i = 0; i < budget && n < 0; i++) begin
            tick(1);
            if (state_dbg === target) n = edge_n;
        end
    endtask

    function automatic logic [7:0] pack(input logic [2:0] dr, input logic ar,
                                        input logic [1:0] st, input logic f, input logic l);
        return {dr, ar, st, f, l};
    endfunction

    initial begin
        int n;

        // Bring-up, RUN heartbeat, lock loss in RUN, fault LED and fault_clear.
        tbl.push_back(vec_t'{0, 2'b11, 3'b111, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{2, 2'b11, 3'b111, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1, 2'b11, 3'b111, 1'b0, 3'b111, 1'b0, 2'd1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{7, 2'b11, 3'b111, 1'b0, 3'b111, 1'b0, 2'd1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1, 2'b11, 3'b111, 1'b0, 3'b110, 1'b0, 2'd2, 1'b0, 1'b0});
        tbl.push_back(vec_t'{3, 2'b11, 3'b111, 1'b0, 3'b110, 1'b0, 2'd2, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1, 2'b11, 3'b111, 1'b0, 3'b100, 1'b0, 2'd2, 1'b0, 1'b0});
        tbl.push_back(vec_t'{4, 2'b11, 3'b111, 1'b0, 3'b000, 1'b0, 2'd2, 1'b0, 1'b0});
        tbl.push_back(vec_t'{3, 2'b11, 3'b111, 1'b0, 3'b000, 1'b0, 2'd2, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1, 2'b11, 3'b111, 1'b0, 3'b000, 1'b1, 2'd3, 1'b0, 1'b0});
        tbl.push_back(vec_t'{9, 2'b11, 3'b111, 1'b0, 3'b000, 1'b1, 2'd3, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1, 2'b11, 3'b111, 1'b0, 3'b000, 1'b1, 2'd3, 1'b0, 1'b1});
        tbl.push_back(vec_t'{9, 2'b11, 3'b111, 1'b0, 3'b000, 1'b1, 2'd3, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1, 2'b11, 3'b111, 1'b0, 3'b000, 1'b1, 2'd3, 1'b0, 1'b0});
        tbl.push_back(vec_t'{2, 2'b00, 3'b111, 1'b0, 3'b000, 1'b1, 2'd3, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1, 2'b00, 3'b111, 1'b0, 3'b111, 1'b0, 2'd0, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1, 2'b00, 3'b111, 1'b0, 3'b111, 1'b0, 2'd0, 1'b1, 1'b0});
        tbl.push_back(vec_t'{2, 2'b00, 3'b111, 1'b0, 3'b111, 1'b0, 2'd0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{1, 2'b00, 3'b111, 1'b1, 3'b111, 1'b0, 2'd0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1, 2'b00, 3'b111, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0});

        do_reset(2'b11, 3'b111);
        foreach (tbl[i]) begin
            lock_in      = tbl[i].lock;
            domain_ready = tbl[i].rdy;
            fault_clear  = tbl[i].clr;
            tick(tbl[i].adv);
            check($sformatf("row%0d {dr,ar,st,fault,led}", i),
                  32'(pack(domain_reset, all_ready, state_dbg, fault, heartbeat_led)),
                  32'(pack(tbl[i].dr, tbl[i].ar, tbl[i].st, tbl[i].flt, tbl[i].led)));
        end

        // One-cycle lock glitch during STRETCH restarts the stretch without a fault.
        do_reset(2'b11, 3'b111);
        tick(5);
        lock_in = 2'b01;
        tick(1);
        lock_in = 2'b11;
        tick(2);
        check("glitch state", 32'(state_dbg), 32'd0);
        check("glitch fault", 32'(fault), 32'd0);
        wait_dr(3'b110, 40, n);
        check("glitch release edge", 32'(n), 32'd17);
        check("glitch fault after", 32'(fault), 32'd0);

        // Domain 1 never ready: timeout, with fault_clear colliding on that edge.
        do_reset(2'b11, 3'b101);
        wait_dr(3'b100, 40, n);
        check("to dr1 fall edge", 32'(n), 32'd15);
        tick(19);
        check("to pre {dr,st,fault}", 32'({domain_reset, state_dbg, fault}), 32'({3'b100, 2'd2, 1'b0}));
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        check("to hit {dr,st,fault}", 32'({domain_reset, state_dbg, fault}), 32'({3'b111, 2'd0, 1'b1}));
        tick(1);
        check("to sticky fault", 32'(fault), 32'd1);
        check("to relock state", 32'(state_dbg), 32'd1);
        wait_state(2'd2, 40, n);
        check("to re-release edge", 32'(n), 32'd44);
        tick(2);
        check("pre-reset {dr,st,fault,led}", 32'({domain_reset, state_dbg, fault, heartbeat_led}),
              32'({3'b110, 2'd2, 1'b1, 1'b1}));

        // Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        #1;
        check("async {dr,ar,st,fault,led}",
              32'(pack(domain_reset, all_ready, state_dbg, fault, heartbeat_led)),
              32'(pack(3'b111, 1'b0, 2'd0, 1'b0, 1'b0)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
